riscv_lsu: RTL
==============

Name: riscv_lsu

Overview:
- Load/store unit sitting directly upstream of the data memory. It accepts one RV32I load/store request from the execute stage over a valid/ready handshake and checks funct3, alignment and address range.
- It drives the memory's word address, byte-select, write-enable and lane-shifted write data. The memory reads combinationally and writes on the clock edge.
- For loads, it extracts and sign- or zero-extends the addressed lanes and returns a registered response with backpressure.

Parameters:
- XLEN, 32, data/address width (RV32 only).
- DMEM_ADDR_BIT, 12, byte-address bits covered by DMEM; word address is DMEM_ADDR_BIT-2 bits.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; asynchronous, active-low.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  LSU can accept.
- i_req_we  in  1  1=store, 0=load.
- i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- i_req_addr  in  XLEN  byte address.
- i_req_wdata  in  XLEN  store data, LSB-justified.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer accepts response.
- o_rsp_rdata  out  XLEN  extended load data; 0 for stores or exceptions.
- o_rsp_exc  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- o_dmem_wr_en  out  1  DMEM write enable.
- o_dmem_addr  out  DMEM_ADDR_BIT-2  word address = addr[DMEM_ADDR_BIT-1:2].
- o_dmem_byte_sel  out  XLEN/8  lane enables.
- o_dmem_data  out  XLEN  lane-shifted store data.
- i_dmem_data  in  XLEN  DMEM read word (combinational from o_dmem_addr).

Behaviour:
- FSM states:
  - IDLE: o_req_ready=1.
  - ACCESS: exactly one cycle.
  - RESP: hold until i_rsp_ready.
- Transitions:
  - IDLE->ACCESS on i_req_valid.
  - ACCESS->RESP always.
  - RESP->IDLE when i_rsp_ready.
- No acceptance outside IDLE.
- On accept, register:
  - address and funct3;
  - we;
  - shifted write data: wdata << 8*addr[1:0];
  - byte_sel:
    - SB: 0001<<addr[1:0]
    - SH: 0011<<addr[1:0]
    - SW: 1111
    - loads use the same lanes.
  - exc code.
- Exception priority: illegal > misaligned > fault.
  - Illegal: store with funct3[2]=1; any funct3 011/110/111.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
  - Fault: addr[XLEN-1:DMEM_ADDR_BIT] != 0.
- o_dmem_addr, o_dmem_byte_sel and o_dmem_data always come from the request registers (stable outside ACCESS).
- o_dmem_wr_en = (state==ACCESS) & we & (exc==00). Combinational from the state register, so it is never high in IDLE/RESP.
- Load capture: at the end of ACCESS, i_dmem_data >> 8*addr[1:0] goes into the response register.
  - Byte: bit 7 sign-extends for LB, zero for LBU.
  - Half: bit 15 sign-extends for LH, zero for LHU.
  - Word: passed unchanged.
- Any exception forces rdata=0 and no write.
- Latency: request accepted at edge N; write/read at N+1; o_rsp_valid high from N+2. Best-case throughput is 1 request per 3 cycles.
- o_rsp_valid is high in RESP only. Response fields are held stable while o_rsp_valid & !i_rsp_ready.
- Reset (async, any state):
  - state=IDLE;
  - o_dmem_wr_en=0 immediately;
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_exc=00;
  - o_dmem_addr=0, o_dmem_byte_sel=0, o_dmem_data=0;
  - o_req_ready=1 while reset is asserted and after release.
- Reset during ACCESS aborts the write. DMEM is unchanged unless the edge already occurred.
- A request held on i_req_valid during RESP is accepted only after the response handshake. It is accepted in the cycle following RESP->IDLE.

Decomposition:
- Shared config header (riscv_configs.v):
  - funct3 encodings (LB..LHU, SB..SW);
  - exc codes;
  - FSM state encodings;
  - XLEN/DMEM_ADDR_BIT defaults.
- One natural sub-module, riscv_lsu_align: purely combinational.
  - Store path: lane shift plus byte_sel.
  - Load path: shift plus sign/zero extend.
  - Exception classification.
- riscv_lsu keeps the FSM and registers.

Test Plan:
- SW 0xDEADBEEF to 0x010, then LW 0x010 -> write cycle shows byte_sel=1111, addr=4, wr_en for exactly 1 cycle; load rsp rdata=0xDEADBEEF, exc=00, valid at accept+2.
- SB 0x80 to 0x013, then LB/LBU 0x013 -> byte_sel=1000, data lane3=0x80; LB=0xFFFFFF80, LBU=0x00000080; other bytes of the word unchanged.
- SH to 0x001 and LW 0x002 -> exc=01, o_dmem_wr_en never asserted, rdata=0; SH 0x1234 to 0x002 then LHU -> 0x00001234.
- LW 0x00001000 (DMEM_ADDR_BIT=12) -> exc=10; store funct3=100 -> exc=11, no write.
- Hold i_rsp_ready=0 for 5 cycles with the next request pending -> rsp fields stable, o_req_ready=0; the next request is accepted the cycle after the handshake.
- Assert i_rstn low mid-ACCESS of a store -> wr_en drops asynchronously, state IDLE, rsp_valid=0; subsequent LW returns the old word.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// exception codes, FSM states and default widths.
package riscv_lsu_pkg;

    localparam int XLEN_DEF          = 32;
    localparam int DMEM_ADDR_BIT_DEF = 12;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_FAULT    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: store shift and byte enables, exception
// classification, and load extraction with sign/zero extension.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int DMEM_ADDR_BIT = DMEM_ADDR_BIT_DEF
) (
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [1:0]                req_off,
    input  logic [XLEN-1:DMEM_ADDR_BIT] req_addr_hi,
    input  logic [XLEN-1:0]           req_wdata,
    output logic [XLEN-1:0]           st_data,
    output logic [XLEN/8-1:0]         st_byte_sel,
    output logic [1:0]                st_exc,
    input  logic [2:0]                ld_funct3,
    input  logic [1:0]                ld_off,
    input  logic [XLEN-1:0]           ld_word,
    output logic [XLEN-1:0]           ld_data
);

    localparam int NB = XLEN / 8;
    localparam logic [NB-1:0] LANE_B = NB'(1);
    localparam logic [NB-1:0] LANE_H = NB'(3);

    logic            illegal;
    logic            misaligned;
    logic            fault;
    logic [XLEN-1:0] ld_shifted;

    assign st_data = req_wdata << {req_off, 3'b000};

    always_comb begin
        st_byte_sel = '0;
        case (req_funct3[1:0])
            2'b00:   st_byte_sel = LANE_B << req_off;
            2'b01:   st_byte_sel = LANE_H << req_off;
            2'b10:   st_byte_sel = '1;
            default: st_byte_sel = '0;
        endcase
    end

    assign illegal    = (req_we && req_funct3[2]) || (req_funct3 == 3'b011) ||
                        (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    assign fault      = |req_addr_hi;

    // Priority: illegal encoding hides alignment, alignment hides range.
    always_comb begin
        st_exc = EXC_OK;
        if (illegal)
            st_exc = EXC_ILLEGAL;
        else if (misaligned)
            st_exc = EXC_MISALIGN;
        else if (fault)
            st_exc = EXC_FAULT;
    end

    assign ld_shifted = ld_word >> {ld_off, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_funct3)
            F3_LB:   ld_data = {{(XLEN-8){ld_shifted[7]}}, ld_shifted[7:0]};
            F3_LH:   ld_data = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            F3_LW:   ld_data = ld_shifted;
            F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_shifted[7:0]};
            F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: accepts one request, drives DMEM for a single
// ACCESS cycle, then holds a registered response until it is taken.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int DMEM_ADDR_BIT = DMEM_ADDR_BIT_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [2:0]               i_req_funct3,
    input  logic [XLEN-1:0]          i_req_addr,
    input  logic [XLEN-1:0]          i_req_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [XLEN-1:0]          o_rsp_rdata,
    output logic [1:0]               o_rsp_exc,
    output logic                     o_dmem_wr_en,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic [XLEN-1:0]          o_dmem_data,
    input  logic [XLEN-1:0]          i_dmem_data
);

    state_e                   state_reg;
    state_e                   state_next;
    logic [DMEM_ADDR_BIT-3:0] word_addr_reg;
    logic [1:0]               off_reg;
    logic [2:0]               funct3_reg;
    logic                     we_reg;
    logic [XLEN-1:0]          wdata_reg;
    logic [XLEN/8-1:0]        byte_sel_reg;
    logic [1:0]               exc_reg;
    logic [XLEN-1:0]          rdata_reg;

    logic [XLEN-1:0]          st_data;
    logic [XLEN/8-1:0]        st_byte_sel;
    logic [1:0]               st_exc;
    logic [XLEN-1:0]          ld_data;
    logic                     accept;

    riscv_lsu_align #(
        .XLEN          (XLEN),
        .DMEM_ADDR_BIT (DMEM_ADDR_BIT)
    ) u_align (
        .req_we      (i_req_we),
        .req_funct3  (i_req_funct3),
        .req_off     (i_req_addr[1:0]),
        .req_addr_hi (i_req_addr[XLEN-1:DMEM_ADDR_BIT]),
        .req_wdata   (i_req_wdata),
        .st_data     (st_data),
        .st_byte_sel (st_byte_sel),
        .st_exc      (st_exc),
        .ld_funct3   (funct3_reg),
        .ld_off      (off_reg),
        .ld_word     (i_dmem_data),
        .ld_data     (ld_data)
    );

    assign accept = (state_reg == ST_IDLE) && i_req_valid;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (i_req_valid) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   if (i_rsp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            word_addr_reg <= '0;
            off_reg       <= '0;
            funct3_reg    <= '0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            byte_sel_reg  <= '0;
            exc_reg       <= EXC_OK;
            rdata_reg     <= '0;
        end else begin
            if (accept) begin
                word_addr_reg <= i_req_addr[DMEM_ADDR_BIT-1:2];
                off_reg       <= i_req_addr[1:0];
                funct3_reg    <= i_req_funct3;
                we_reg        <= i_req_we;
                wdata_reg     <= st_data;
                byte_sel_reg  <= st_byte_sel;
                exc_reg       <= st_exc;
            end
            // Stores and faulting requests respond with zero data.
            if (state_reg == ST_ACCESS)
                rdata_reg <= (!we_reg && (exc_reg == EXC_OK)) ? ld_data : '0;
        end
    end

    assign o_req_ready     = (state_reg == ST_IDLE);
    assign o_rsp_valid     = (state_reg == ST_RESP);
    assign o_rsp_rdata     = rdata_reg;
    assign o_rsp_exc       = exc_reg;
    assign o_dmem_wr_en    = (state_reg == ST_ACCESS) && we_reg && (exc_reg == EXC_OK);
    assign o_dmem_addr     = word_addr_reg;
    assign o_dmem_byte_sel = byte_sel_reg;
    assign o_dmem_data     = wdata_reg;

endmodule
